// File: rtl/jups_disp_pkg.sv
// Shared definitions for the 7-segment display path.
//   BCD_W       : width of one BCD digit code
//   disp_state_e: conversion sequencer states
//   min_digits(): decimal digits needed to show any WIDTH-bit unsigned value
package jups_disp_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } disp_state_e;

    // floor(width * log10(2)) + 1 = digit count of 2^width - 1
    // (2^width is never a power of ten, so the floor form is exact)
    function automatic int min_digits(input int width);
        return (width * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_adjust.sv
// Add-3 correction stage of the double-dabble converter.
//   bcd_i : DIGITS packed BCD nibbles, digit 0 in the low nibble
//   bcd_o : same nibbles, each incremented by 3 when it is >= 5
module bcd_adjust
    import jups_disp_pkg::*;
#(
    parameter int DIGITS = 5
) (
    input  logic [BCD_W*DIGITS-1:0] bcd_i,
    output logic [BCD_W*DIGITS-1:0] bcd_o
);

    always_comb begin
        bcd_o = bcd_i;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            // carry out of the nibble is dropped; legal parameters keep it at 0
            if (bcd_i[k*BCD_W +: BCD_W] >= 4'd5)
                bcd_o[k*BCD_W +: BCD_W] = bcd_i[k*BCD_W +: BCD_W] + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_output_port.sv
// Binary-to-BCD output port feeding the per-digit 7-segment decoders.
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-high
//   start    : conversion request, sampled only while idle
//   value    : unsigned binary operand, captured when start is accepted
//   busy     : high while converting or presenting the result
//   done     : one-cycle pulse, coincident with the digit update
//   digits   : BCD codes, digit i in bits [4i+3:4i]
//   digit_on : per-digit decoder enable (1 = show, 0 = blank)
module bcd_output_port
    import jups_disp_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 5,
    parameter int LZ_BLANK = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        value,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] digits,
    output logic [DIGITS-1:0]       digit_on
);

    localparam int BW = BCD_W * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    if (DIGITS < min_digits(WIDTH)) begin : g_param_check
        $error("bcd_output_port: DIGITS too small for WIDTH");
    end

    disp_state_e     state_q, state_d;
    logic [SW-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   digits_q, digits_d;
    logic [DIGITS-1:0] on_q, on_d;

    logic [BW-1:0]   adj;
    logic [SW-1:0]   shifted;
    logic [BW-1:0]   bcd_next;
    logic [DIGITS-1:0] on_next;
    logic            last;

    bcd_adjust #(.DIGITS(DIGITS)) u_adjust (
        .bcd_i (shreg_q[SW-1 -: BW]),
        .bcd_o (adj)
    );

    assign shifted  = {adj, shreg_q[WIDTH-1:0]} << 1;
    assign bcd_next = shifted[SW-1 -: BW];
    assign last     = (cnt_q == CW'(WIDTH - 1));

    // Enable is computed from the final BCD field so it lands with the digits.
    always_comb begin
        logic seen;
        int unsigned idx;
        seen    = 1'b0;
        idx     = 0;
        on_next = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            idx  = DIGITS - 1 - k;
            seen = seen | (bcd_next[idx*BCD_W +: BCD_W] != '0);
            on_next[idx] = seen || (idx == 0) || (LZ_BLANK == 0);
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONVERT;
            CONVERT: if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Datapath next-state
    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        on_d     = on_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = SW'(value);
                    cnt_d   = '0;
                end
            end
            CONVERT: begin
                shreg_d = shifted;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    digits_d = bcd_next;
                    on_d     = on_next;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg_q  <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            on_q     <= '0;
        end else begin
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            on_q     <= on_d;
        end
    end

    assign digits   = digits_q;
    assign digit_on = on_q;

endmodule

// File: tb/tb_bcd_output_port.sv
module tb_bcd_output_port;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] value = '0;

    logic        busy, done, busy_n, done_n;
    logic [19:0] digits, digits_n;
    logic [4:0]  digit_on, digit_on_n;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [19:0] prev_digits = '0;
    logic [4:0]  prev_on     = '0;

    bcd_output_port #(.WIDTH(16), .DIGITS(5), .LZ_BLANK(1)) dut (
        .clock(clock), .reset(reset), .start(start), .value(value),
        .busy(busy), .done(done), .digits(digits), .digit_on(digit_on)
    );

    bcd_output_port #(.WIDTH(16), .DIGITS(5), .LZ_BLANK(0)) dut_nolz (
        .clock(clock), .reset(reset), .start(start), .value(value),
        .busy(busy_n), .done(done_n), .digits(digits_n), .digit_on(digit_on_n)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Decimal reference: peel digits off with /10 and %10.
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Digit k is shown when the number has more than k decimal digits.
    function automatic logic [4:0] ref_on(input int unsigned v, input bit lz);
        logic [4:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            r[k] = !lz || (k == 0) || (v >= p);
            p = p * 10;
        end
        return r;
    endfunction

    // mode 0: quiet inputs, 1: random start/value noise while busy,
    // 2: start pulse with value 999 in CONVERT cycle 5, then value changes
    task automatic run(input int unsigned v, input int mode);
        int guard;
        int lat;
        int nbusy;
        bit stable;
        guard = 0;
        while (busy && guard < 50) begin
            tick;
            guard++;
        end
        start = 1'b1;
        value = 16'(v);
        tick;
        start  = 1'b0;
        lat    = 0;
        nbusy  = busy ? 1 : 0;
        stable = 1'b1;
        while (!done && lat < 40) begin
            if (digits !== prev_digits || digit_on !== prev_on) stable = 1'b0;
            if (mode == 1) begin
                start = 1'($urandom_range(0, 1));
                value = 16'($urandom);
            end else if (mode == 2) begin
                start = (lat == 4);
                value = (lat == 4) ? 16'd999 : 16'(12345 + lat);
            end
            tick;
            lat++;
            if (busy) nbusy++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 32'(lat), 32'd16);
        check("hold_during_convert", 32'(stable), 32'd1);
        check("latency", 32'(lat), 32'd16);
        check("busy_cycles", 32'(nbusy), 32'd17);
        check("digits", 32'(digits), 32'(ref_bcd(v)));
        check("digit_on", 32'(digit_on), 32'(ref_on(v, 1'b1)));
        check("digits_nolz", 32'(digits_n), 32'(ref_bcd(v)));
        check("digit_on_nolz", 32'(digit_on_n), 32'(ref_on(v, 1'b0)));
        prev_digits = ref_bcd(v);
        prev_on     = ref_on(v, 1'b1);
        tick;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int t1, t2, guard, ndone;

        tick;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_digits", 32'(digits), 32'd0);
        check("rst_digit_on", 32'(digit_on), 32'd0);
        check("rst_digit_on_nolz", 32'(digit_on_n), 32'd0);
        reset = 1'b0;
        tick;

        run(0, 0);
        check("zero_digit_on", 32'(digit_on), 32'h01);
        run(65535, 0);
        check("max_digits", 32'(digits), 32'h65535);
        run(1234, 0);
        check("1234_digit_on", 32'(digit_on), 32'h0F);
        check("1234_digit_on_nolz", 32'(digit_on_n), 32'h1F);

        run(42, 2);
        check("ignore_start_busy", 32'(digits), 32'h00042);
        check("ignore_digit_on", 32'(digit_on), 32'h03);

        // reset in CONVERT cycle 8 aborts and blanks the shown result
        run(9, 0);
        start = 1'b1;
        value = 16'd500;
        tick;
        start = 1'b0;
        repeat (7) tick;
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_digits", 32'(digits), 32'd0);
        check("arst_digit_on", 32'(digit_on), 32'd0);
        check("arst_digit_on_nolz", 32'(digit_on_n), 32'd0);
        tick;
        reset = 1'b0;
        prev_digits = '0;
        prev_on     = '0;
        ndone = 0;
        repeat (30) begin
            tick;
            if (done || busy) ndone++;
        end
        check("no_done_after_abort", 32'(ndone), 32'd0);

        // back-to-back with start held high
        start = 1'b1;
        value = 16'd7;
        tick;
        value = 16'd10000;
        guard = 0;
        while (!done && guard < 40) begin tick; guard++; end
        t1 = cyc;
        check("b2b_first_seen", 32'(done), 32'd1);
        check("b2b_first_digits", 32'(digits), 32'h00007);
        tick;
        guard = 0;
        while (!done && guard < 40) begin tick; guard++; end
        t2 = cyc;
        start = 1'b0;
        check("b2b_second_seen", 32'(done), 32'd1);
        check("b2b_period", 32'(t2 - t1), 32'd18);
        check("b2b_second_digits", 32'(digits), 32'h10000);
        check("b2b_second_digit_on", 32'(digit_on), 32'h1F);
        prev_digits = 20'h10000;
        prev_on     = 5'h1F;
        tick;

        for (int i = 0; i < 1000; i++) begin
            run($urandom_range(0, 65535), 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
